// File: rtl/raster_pkg.sv
// Shared raster types: coordinate widths, screen limits, vertex layout
// and the scanner state encoding.
package raster_pkg;

  localparam int COORD_W  = 9;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  localparam int VX = 2;
  localparam int VY = 1;
  localparam int VZ = 0;

  typedef logic [COORD_W-1:0] coord_t;

  // Component-major so that v[VX] is a full-width x coordinate.
  typedef logic [2:0][COORD_W-1:0] vert_t;

  typedef enum logic [2:0] {
    IDLE,
    BBOX,
    ISSUE,
    WAIT,
    EMIT,
    ADV,
    DONE
  } scan_state_t;

  localparam coord_t X_LIM = coord_t'(SCREEN_W - 1);
  localparam coord_t Y_LIM = coord_t'(SCREEN_H - 1);

  function automatic coord_t clamp(coord_t v, coord_t lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic coord_t min3(coord_t a, coord_t b, coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic coord_t max3(coord_t a, coord_t b, coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

endpackage

// File: rtl/tri_bbox_scanner_if.sv
// Triangle in, tester request/verdict and covered-pixel handshakes
// of the bounding-box scanner.
interface tri_bbox_scanner_if;
  import raster_pkg::*;

  logic   tri_valid_in;
  logic   tri_ready_out;
  vert_t  v1_in;
  vert_t  v2_in;
  vert_t  v3_in;
  vert_t  v1_out;
  vert_t  v2_out;
  vert_t  v3_out;
  coord_t test_x_out;
  coord_t test_y_out;
  logic   test_valid_out;
  logic   in_tri_in;
  logic   in_tri_valid_in;
  coord_t pix_x_out;
  coord_t pix_y_out;
  logic   pix_valid_out;
  logic   pix_ready_in;
  logic   busy_out;
  logic   done_out;

  modport slave (
    input  tri_valid_in, v1_in, v2_in, v3_in,
    input  in_tri_in, in_tri_valid_in, pix_ready_in,
    output tri_ready_out, v1_out, v2_out, v3_out,
    output test_x_out, test_y_out, test_valid_out,
    output pix_x_out, pix_y_out, pix_valid_out,
    output busy_out, done_out
  );

  modport master (
    output tri_valid_in, v1_in, v2_in, v3_in,
    output in_tri_in, in_tri_valid_in, pix_ready_in,
    input  tri_ready_out, v1_out, v2_out, v3_out,
    input  test_x_out, test_y_out, test_valid_out,
    input  pix_x_out, pix_y_out, pix_valid_out,
    input  busy_out, done_out
  );

endinterface

// File: rtl/tri_bbox_calc.sv
// Combinational bounding box of three vertices, each bound clamped
// to the last visible column/row.
module tri_bbox_calc
  import raster_pkg::*;
(
  input  coord_t x1_i,
  input  coord_t x2_i,
  input  coord_t x3_i,
  input  coord_t y1_i,
  input  coord_t y2_i,
  input  coord_t y3_i,
  output coord_t xmin_o,
  output coord_t xmax_o,
  output coord_t ymin_o,
  output coord_t ymax_o
);

  assign xmin_o = clamp(min3(x1_i, x2_i, x3_i), X_LIM);
  assign xmax_o = clamp(max3(x1_i, x2_i, x3_i), X_LIM);
  assign ymin_o = clamp(min3(y1_i, y2_i, y3_i), Y_LIM);
  assign ymax_o = clamp(max3(y1_i, y2_i, y3_i), Y_LIM);

endmodule

// File: rtl/tri_bbox_scanner.sv
// Walks a triangle's clamped bounding box row-major, asks the tester
// about each pixel and forwards covered pixels downstream.
module tri_bbox_scanner
  import raster_pkg::*;
(
  input  logic clk_in,
  input  logic rst_in,
  tri_bbox_scanner_if.slave bus
);

  scan_state_t state_q;
  vert_t  v1_q, v2_q, v3_q;
  coord_t xmin_q, xmax_q, ymax_q;
  coord_t cx_q, cy_q;
  coord_t cx_d, cy_d;
  logic   last_d;
  coord_t test_x_q, test_y_q;
  coord_t pix_x_q, pix_y_q;
  logic   test_valid_q, pix_valid_q, done_q;
  coord_t bx_min, bx_max, by_min, by_max;

  tri_bbox_calc u_calc (
    .x1_i   (v1_q[VX]),
    .x2_i   (v2_q[VX]),
    .x3_i   (v3_q[VX]),
    .y1_i   (v1_q[VY]),
    .y2_i   (v2_q[VY]),
    .y3_i   (v3_q[VY]),
    .xmin_o (bx_min),
    .xmax_o (bx_max),
    .ymin_o (by_min),
    .ymax_o (by_max)
  );

  always_comb begin
    cx_d   = cx_q;
    cy_d   = cy_q;
    last_d = 1'b0;
    if (cx_q < xmax_q) begin
      cx_d = cx_q + coord_t'(1);
    end else if (cy_q < ymax_q) begin
      cx_d = xmin_q;
      cy_d = cy_q + coord_t'(1);
    end else begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      v1_q         <= '0;
      v2_q         <= '0;
      v3_q         <= '0;
      xmin_q       <= '0;
      xmax_q       <= '0;
      ymax_q       <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      test_x_q     <= '0;
      test_y_q     <= '0;
      test_valid_q <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.tri_valid_in) begin
            v1_q    <= bus.v1_in;
            v2_q    <= bus.v2_in;
            v3_q    <= bus.v3_in;
            state_q <= BBOX;
          end
        end
        // Request is raised on entry so it is high during ISSUE.
        BBOX: begin
          xmin_q       <= bx_min;
          xmax_q       <= bx_max;
          ymax_q       <= by_max;
          cx_q         <= bx_min;
          cy_q         <= by_min;
          test_x_q     <= bx_min;
          test_y_q     <= by_min;
          test_valid_q <= 1'b1;
          state_q      <= ISSUE;
        end
        ISSUE: begin
          test_valid_q <= 1'b0;
          state_q      <= WAIT;
        end
        WAIT: begin
          if (bus.in_tri_valid_in) begin
            if (bus.in_tri_in) begin
              pix_x_q     <= cx_q;
              pix_y_q     <= cy_q;
              pix_valid_q <= 1'b1;
              state_q     <= EMIT;
            end else begin
              state_q <= ADV;
            end
          end
        end
        EMIT: begin
          if (bus.pix_ready_in) begin
            pix_valid_q <= 1'b0;
            state_q     <= ADV;
          end
        end
        ADV: begin
          if (last_d) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            test_x_q     <= cx_d;
            test_y_q     <= cy_d;
            test_valid_q <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tri_ready_out  = (state_q == IDLE);
  assign bus.busy_out       = (state_q != IDLE);
  assign bus.v1_out         = v1_q;
  assign bus.v2_out         = v2_q;
  assign bus.v3_out         = v3_q;
  assign bus.test_x_out     = test_x_q;
  assign bus.test_y_out     = test_y_q;
  assign bus.test_valid_out = test_valid_q;
  assign bus.pix_x_out      = pix_x_q;
  assign bus.pix_y_out      = pix_y_q;
  assign bus.pix_valid_out  = pix_valid_q;
  assign bus.done_out       = done_q;

endmodule

// File: tb/tb_tri_bbox_scanner.sv
// Bench for tri_bbox_scanner: 3-cycle tester model, raster-order
// scoreboard and directed triangles.
module tb_tri_bbox_scanner;
  import raster_pkg::*;

  typedef struct { int x; int y; } pt_t;
  typedef struct { vert_t a; vert_t b; vert_t c; } tri_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tri_bbox_scanner_if bus ();

  tri_bbox_scanner dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int passed = 0;

  pt_t  exp_t[$];
  pt_t  exp_p[$];
  tri_t exp_v[$];
  int   exp_n[$];
  int   exp_np[$];

  int verdict_mode = 0;
  logic [2:0] pipe = '0;
  bit chk_en = 1'b0;
  bit stall_q = 1'b0;
  int sx = 0, sy = 0;
  int cur_t = 0, cur_p = 0, done_cnt = 0;
  int n_t = 0, n_p = 0, max_x = 0, max_y = 0;
  pt_t first_t, second_t, last_t;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic vert_t mkv(int x, int y, int z);
    vert_t v;
    v[VX] = coord_t'(x);
    v[VY] = coord_t'(y);
    v[VZ] = coord_t'(z);
    return v;
  endfunction

  function automatic tri_t mkt(vert_t a, vert_t b, vert_t c);
    tri_t t;
    t.a = a; t.b = b; t.c = c;
    return t;
  endfunction

  function automatic int lim(int v, int l);
    return (v > l) ? l : v;
  endfunction

  // Reference: every box pixel in raster order, verdict from the mode.
  task automatic model_tri(tri_t t, int mode);
    int xs[3], ys[3];
    int x0, x1, y0, y1;
    pt_t p;
    xs[0] = int'(t.a[VX]); xs[1] = int'(t.b[VX]); xs[2] = int'(t.c[VX]);
    ys[0] = int'(t.a[VY]); ys[1] = int'(t.b[VY]); ys[2] = int'(t.c[VY]);
    x0 = xs[0]; x1 = xs[0]; y0 = ys[0]; y1 = ys[0];
    for (int i = 1; i < 3; i++) begin
      if (xs[i] < x0) x0 = xs[i];
      if (xs[i] > x1) x1 = xs[i];
      if (ys[i] < y0) y0 = ys[i];
      if (ys[i] > y1) y1 = ys[i];
    end
    x0 = lim(x0, SCREEN_W - 1); x1 = lim(x1, SCREEN_W - 1);
    y0 = lim(y0, SCREEN_H - 1); y1 = lim(y1, SCREEN_H - 1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        p.x = x; p.y = y;
        exp_t.push_back(p);
        if (mode == 1) exp_p.push_back(p);
      end
    exp_v.push_back(t);
    exp_n.push_back((x1 - x0 + 1) * (y1 - y0 + 1));
    exp_np.push_back(mode == 1 ? (x1 - x0 + 1) * (y1 - y0 + 1) : 0);
  endtask

  // Tester: answers three edges after each request.
  always @(negedge clk) begin
    pipe = {pipe[1:0], bus.test_valid_out};
    bus.in_tri_valid_in = pipe[2];
    bus.in_tri_in = pipe[2] & (verdict_mode == 1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (bus.test_valid_out) begin
        pt_t e;
        if (exp_t.size() == 0) begin
          check("test_unexpected", 1, 0);
        end else begin
          e = exp_t.pop_front();
          check("test_x", int'(bus.test_x_out), e.x);
          check("test_y", int'(bus.test_y_out), e.y);
        end
        if (exp_v.size() > 0) begin
          check("v1_out", int'(bus.v1_out), int'(exp_v[0].a));
          check("v2_out", int'(bus.v2_out), int'(exp_v[0].b));
          check("v3_out", int'(bus.v3_out), int'(exp_v[0].c));
        end
        if (n_t == 0) begin
          first_t.x = int'(bus.test_x_out); first_t.y = int'(bus.test_y_out);
        end
        if (n_t == 1) begin
          second_t.x = int'(bus.test_x_out); second_t.y = int'(bus.test_y_out);
        end
        last_t.x = int'(bus.test_x_out); last_t.y = int'(bus.test_y_out);
        if (int'(bus.test_x_out) > max_x) max_x = int'(bus.test_x_out);
        if (int'(bus.test_y_out) > max_y) max_y = int'(bus.test_y_out);
        n_t++; cur_t++;
      end
      if (stall_q) begin
        check("stall_valid", int'(bus.pix_valid_out), 1);
        check("stall_x", int'(bus.pix_x_out), sx);
        check("stall_y", int'(bus.pix_y_out), sy);
        check("stall_no_test", int'(bus.test_valid_out), 0);
      end
      if (bus.pix_valid_out && bus.pix_ready_in) begin
        pt_t e;
        if (exp_p.size() == 0) begin
          check("pix_unexpected", 1, 0);
        end else begin
          e = exp_p.pop_front();
          check("pix_x", int'(bus.pix_x_out), e.x);
          check("pix_y", int'(bus.pix_y_out), e.y);
        end
        n_p++; cur_p++;
      end
      if (bus.done_out) begin
        if (exp_n.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          check("done_tests", cur_t, exp_n.pop_front());
          check("done_pix", cur_p, exp_np.pop_front());
          exp_v.delete(0);
        end
        check("done_busy", int'(bus.busy_out), 1);
        cur_t = 0; cur_p = 0;
        done_cnt++;
      end
      stall_q = bus.pix_valid_out && !bus.pix_ready_in;
      sx = int'(bus.pix_x_out);
      sy = int'(bus.pix_y_out);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(tri_t t);
    int k;
    bus.v1_in = t.a; bus.v2_in = t.b; bus.v3_in = t.c;
    bus.tri_valid_in = 1'b1;
    k = 0;
    while (!bus.tri_ready_out && k < 200) begin step(); k++; end
    if (!bus.tri_ready_out) check("accept_timeout", 0, 1);
    step();
    bus.tri_valid_in = 1'b0;
  endtask

  task automatic wait_done(int target, int budget);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin step(); k++; end
    if (done_cnt < target) check("done_timeout", done_cnt, target);
  endtask

  task automatic clear_stats();
    n_t = 0; n_p = 0; max_x = 0; max_y = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tri_t t, ta, tb;
    int tgt, k;
    bus.tri_valid_in = 1'b0;
    bus.v1_in = '0; bus.v2_in = '0; bus.v3_in = '0;
    bus.pix_ready_in = 1'b1;
    repeat (3) step();
    check("rst_ready", int'(bus.tri_ready_out), 1);
    check("rst_busy", int'(bus.busy_out), 0);
    check("rst_test_valid", int'(bus.test_valid_out), 0);
    check("rst_pix_valid", int'(bus.pix_valid_out), 0);
    check("rst_done", int'(bus.done_out), 0);
    check("rst_v1", int'(bus.v1_out), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    // Single-pixel triangle
    verdict_mode = 0;
    t = mkt(mkv(5, 7, 1), mkv(5, 7, 2), mkv(5, 7, 3));
    model_tri(t, 0); clear_stats(); tgt = done_cnt + 1;
    send(t); wait_done(tgt, 100);
    check("pt_ntests", n_t, 1);
    check("pt_x", first_t.x, 5);
    check("pt_y", first_t.y, 7);
    check("pt_ready_again", int'(bus.tri_ready_out), 1);

    // Raster order, nothing covered
    t = mkt(mkv(20, 30, 0), mkv(10, 40, 0), mkv(15, 25, 0));
    model_tri(t, 0); clear_stats(); tgt = done_cnt + 1;
    send(t); wait_done(tgt, 3000);
    check("ord_ntests", n_t, 176);
    check("ord_first_x", first_t.x, 10);
    check("ord_first_y", first_t.y, 25);
    check("ord_second_x", second_t.x, 11);
    check("ord_second_y", second_t.y, 25);
    check("ord_last_x", last_t.x, 20);
    check("ord_last_y", last_t.y, 40);
    check("ord_npix", n_p, 0);

    // Clamping at the screen edge
    t = mkt(mkv(310, 230, 0), mkv(400, 235, 0), mkv(315, 300, 0));
    model_tri(t, 0); clear_stats(); tgt = done_cnt + 1;
    send(t); wait_done(tgt, 2000);
    check("clamp_ntests", n_t, 100);
    check("clamp_max_x", max_x, 319);
    check("clamp_max_y", max_y, 239);
    check("clamp_first_x", first_t.x, 310);

    // Downstream stall on the first covered pixel
    verdict_mode = 1;
    bus.pix_ready_in = 1'b0;
    t = mkt(mkv(2, 3, 0), mkv(4, 3, 0), mkv(3, 4, 0));
    model_tri(t, 1); clear_stats(); tgt = done_cnt + 1;
    send(t);
    k = 0;
    while (!bus.pix_valid_out && k < 50) begin step(); k++; end
    check("bp_pix_seen", int'(bus.pix_valid_out), 1);
    repeat (5) step();
    check("bp_hold_x", int'(bus.pix_x_out), 2);
    check("bp_hold_y", int'(bus.pix_y_out), 3);
    check("bp_tests_during_stall", n_t, 1);
    bus.pix_ready_in = 1'b1;
    wait_done(tgt, 200);
    check("bp_npix", n_p, 6);
    check("bp_next_x", second_t.x, 3);
    check("bp_next_y", second_t.y, 3);

    // Reset while waiting for a verdict
    verdict_mode = 0;
    t = mkt(mkv(20, 30, 0), mkv(10, 40, 0), mkv(15, 25, 0));
    model_tri(t, 0); clear_stats();
    send(t);
    k = 0;
    while (n_t < 3 && k < 100) begin step(); k++; end
    k = 0;
    while (!bus.test_valid_out && k < 20) begin step(); k++; end
    step();
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_ready", int'(bus.tri_ready_out), 1);
    check("mrst_busy", int'(bus.busy_out), 0);
    check("mrst_test_valid", int'(bus.test_valid_out), 0);
    check("mrst_test_x", int'(bus.test_x_out), 0);
    check("mrst_v1", int'(bus.v1_out), 0);
    exp_t.delete(); exp_p.delete(); exp_v.delete();
    exp_n.delete(); exp_np.delete();
    cur_t = 0; cur_p = 0; stall_q = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("late_verdict_ready", int'(bus.tri_ready_out), 1);
      check("late_verdict_test", int'(bus.test_valid_out), 0);
    end
    chk_en = 1'b1;

    // Second triangle held on the input while busy
    ta = mkt(mkv(1, 1, 4), mkv(2, 1, 5), mkv(1, 2, 6));
    tb = mkt(mkv(8, 9, 7), mkv(8, 9, 8), mkv(9, 9, 9));
    model_tri(ta, 0); model_tri(tb, 0);
    clear_stats(); tgt = done_cnt + 1;
    send(ta);
    bus.v1_in = tb.a; bus.v2_in = tb.b; bus.v3_in = tb.c;
    bus.tri_valid_in = 1'b1;
    k = 0;
    while (!bus.done_out && k < 200) begin step(); k++; end
    check("gate_done_seen", int'(bus.done_out), 1);
    check("gate_ready_in_done", int'(bus.tri_ready_out), 0);
    check("gate_v1_still_a", int'(bus.v1_out), int'(ta.a));
    step();
    check("gate_ready_after", int'(bus.tri_ready_out), 1);
    step();
    bus.tri_valid_in = 1'b0;
    check("gate_v1_b", int'(bus.v1_out), int'(tb.a));
    check("gate_v3_b", int'(bus.v3_out), int'(tb.c));
    wait_done(tgt + 1, 200);
    check("gate_total_tests", n_t, 6);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
